// File: rtl/status_reg_capture_pkg.sv
// Shared definitions for the status/control register blocks.
// Provides the common bus width and the valid-bit mask helper.
package status_reg_capture_pkg;

    localparam int unsigned CY_STATUS_WIDTH = 8;

    // Low n bits set; the remaining bits are forced to zero everywhere.
    function automatic logic [CY_STATUS_WIDTH-1:0] valid_bits(input int unsigned n);
        logic [CY_STATUS_WIDTH-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < CY_STATUS_WIDTH; i++) begin
            v[i] = (i < n);
        end
        return v;
    endfunction

endpackage

// File: rtl/status_reg_capture_if.sv
// Fabric/CPU-side signal bundle for the status register block.
// The master drives status, read strobe and mask writes; the slave returns data and interrupt.
interface status_reg_capture_if;
    import status_reg_capture_pkg::*;

    logic [CY_STATUS_WIDTH-1:0] status_in;
    logic                       rd_req;
    logic [CY_STATUS_WIDTH-1:0] rd_data;
    logic                       rd_valid;
    logic                       mask_wr;
    logic [CY_STATUS_WIDTH-1:0] mask_data;
    logic                       interrupt;

    modport master (
        output status_in,
        output rd_req,
        output mask_wr,
        output mask_data,
        input  rd_data,
        input  rd_valid,
        input  interrupt
    );

    modport slave (
        input  status_in,
        input  rd_req,
        input  mask_wr,
        input  mask_data,
        output rd_data,
        output rd_valid,
        output interrupt
    );

endinterface

// File: rtl/status_sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous active-high reset.
module status_sync_2ff (
    input  logic clock,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/status_reg_capture.sv
// Status register: captures fabric status bits as transparent or sticky (clear-on-read)
// values, returns them on a CPU read strobe and raises a masked, registered interrupt.
module status_reg_capture
    import status_reg_capture_pkg::*;
#(
    parameter int unsigned                NumInputs  = 8,
    parameter logic [CY_STATUS_WIDTH-1:0] StickyMask = 8'h00,
    parameter logic [CY_STATUS_WIDTH-1:0] EdgeMask   = 8'h00,
    parameter int unsigned                SyncInputs = 1,
    parameter logic [CY_STATUS_WIDTH-1:0] IntrMask   = 8'h00
) (
    input logic                 clock,
    input logic                 reset,
    status_reg_capture_if.slave bus
);

    localparam logic [CY_STATUS_WIDTH-1:0] ValidMask = valid_bits(NumInputs);

    logic [CY_STATUS_WIDTH-1:0] w_s;
    logic [CY_STATUS_WIDTH-1:0] w_ev;
    logic [CY_STATUS_WIDTH-1:0] w_clr;
    logic [CY_STATUS_WIDTH-1:0] w_st_d;
    logic [CY_STATUS_WIDTH-1:0] w_mask_d;

    logic [CY_STATUS_WIDTH-1:0] r_s_prev;
    logic [CY_STATUS_WIDTH-1:0] r_st;
    logic [CY_STATUS_WIDTH-1:0] r_mask;
    logic [CY_STATUS_WIDTH-1:0] r_rd_data;
    logic                       r_rd_valid;
    logic                       r_interrupt;

    for (genvar gi = 0; gi < int'(CY_STATUS_WIDTH); gi++) begin : g_in
        if (SyncInputs != 0 && gi < int'(NumInputs)) begin : g_sync
            status_sync_2ff u_sync (
                .clock (clock),
                .reset (reset),
                .i_d   (bus.status_in[gi]),
                .o_q   (w_s[gi])
            );
        end else if (SyncInputs != 0) begin : g_tie
            assign w_s[gi] = 1'b0;
        end else begin : g_comb
            assign w_s[gi] = bus.status_in[gi] & ValidMask[gi];
        end
    end

    always_comb begin
        w_ev     = '0;
        w_clr    = '0;
        w_st_d   = '0;
        w_mask_d = r_mask;
        w_ev     = ((EdgeMask & w_s & ~r_s_prev) | (~EdgeMask & w_s)) & ValidMask;
        if (bus.rd_req) begin
            w_clr = r_st & StickyMask;
        end
        // Events arriving with the clearing read survive, so nothing is lost.
        w_st_d = ((StickyMask & ((r_st & ~w_clr) | w_ev)) | (~StickyMask & w_s)) & ValidMask;
        if (bus.mask_wr) begin
            w_mask_d = bus.mask_data & ValidMask;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s_prev    <= '0;
            r_st        <= '0;
            r_mask      <= IntrMask & ValidMask;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_interrupt <= 1'b0;
        end else begin
            r_s_prev    <= w_s;
            r_st        <= w_st_d;
            r_mask      <= w_mask_d;
            r_rd_valid  <= bus.rd_req;
            r_interrupt <= |(r_st & r_mask);
            if (bus.rd_req) begin
                r_rd_data <= r_st;
            end
        end
    end

    assign bus.rd_data   = r_rd_data;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.interrupt = r_interrupt;

endmodule

// File: tb/tb_status_reg_capture.sv
// Directed bench for status_reg_capture: three configurations (synchronized sticky,
// mixed sticky/edge unsynchronized, narrow transparent) driven from one sequence.
module tb_status_reg_capture;

    logic clk;
    logic rst_a;
    logic rst_b;
    logic rst_c;
    int   n_checks;
    int   n_errors;

    status_reg_capture_if bus_a ();
    status_reg_capture_if bus_b ();
    status_reg_capture_if bus_c ();

    status_reg_capture #(
        .NumInputs  (8),
        .StickyMask (8'hFF),
        .EdgeMask   (8'h00),
        .SyncInputs (1),
        .IntrMask   (8'h01)
    ) dut_a (
        .clock (clk),
        .reset (rst_a),
        .bus   (bus_a)
    );

    status_reg_capture #(
        .NumInputs  (8),
        .StickyMask (8'h0F),
        .EdgeMask   (8'h02),
        .SyncInputs (0),
        .IntrMask   (8'h00)
    ) dut_b (
        .clock (clk),
        .reset (rst_b),
        .bus   (bus_b)
    );

    status_reg_capture #(
        .NumInputs  (3),
        .StickyMask (8'h00),
        .EdgeMask   (8'h00),
        .SyncInputs (0),
        .IntrMask   (8'h00)
    ) dut_c (
        .clock (clk),
        .reset (rst_c),
        .bus   (bus_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] stat;
        logic [7:0] mask;
        logic [7:0] exp_rd;
        logic       exp_int;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        vecs[0] = '{stat: 8'hFF, mask: 8'hF8, exp_rd: 8'h07, exp_int: 1'b0};
        vecs[1] = '{stat: 8'hFF, mask: 8'h07, exp_rd: 8'h07, exp_int: 1'b1};
        vecs[2] = '{stat: 8'h05, mask: 8'h02, exp_rd: 8'h05, exp_int: 1'b0};
        vecs[3] = '{stat: 8'h02, mask: 8'h02, exp_rd: 8'h02, exp_int: 1'b1};
        vecs[4] = '{stat: 8'h00, mask: 8'hFF, exp_rd: 8'h00, exp_int: 1'b0};
        vecs[5] = '{stat: 8'h04, mask: 8'hFF, exp_rd: 8'h04, exp_int: 1'b1};
        vecs[6] = '{stat: 8'hF8, mask: 8'hFF, exp_rd: 8'h00, exp_int: 1'b0};

        rst_a = 1'b1;
        rst_b = 1'b1;
        rst_c = 1'b1;
        bus_a.status_in = '0; bus_a.rd_req = 1'b0; bus_a.mask_wr = 1'b0; bus_a.mask_data = '0;
        bus_b.status_in = '0; bus_b.rd_req = 1'b0; bus_b.mask_wr = 1'b0; bus_b.mask_data = '0;
        bus_c.status_in = '0; bus_c.rd_req = 1'b0; bus_c.mask_wr = 1'b0; bus_c.mask_data = '0;
        tick();
        tick();
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        tick();

        // Reset state and idle read
        check("a_reset_rd_data", bus_a.rd_data, 8'h00);
        check("a_reset_rd_valid", {7'b0, bus_a.rd_valid}, 8'h00);
        check("a_reset_int", {7'b0, bus_a.interrupt}, 8'h00);
        bus_a.rd_req = 1'b1;
        tick();
        bus_a.rd_req = 1'b0;
        check("a_idle_rd_data", bus_a.rd_data, 8'h00);
        check("a_idle_rd_valid", {7'b0, bus_a.rd_valid}, 8'h01);
        tick();
        check("a_idle_rd_valid_drop", {7'b0, bus_a.rd_valid}, 8'h00);
        check("a_idle_int", {7'b0, bus_a.interrupt}, 8'h00);

        // One-cycle pulse through the synchronizer; interrupt on the fourth edge
        bus_a.status_in = 8'h01;
        tick();
        bus_a.status_in = 8'h00;
        tick();
        tick();
        check("a_int_edge3", {7'b0, bus_a.interrupt}, 8'h00);
        tick();
        check("a_int_edge4", {7'b0, bus_a.interrupt}, 8'h01);
        bus_a.rd_req = 1'b1;
        tick();
        bus_a.rd_req = 1'b0;
        check("a_sticky_rd", bus_a.rd_data, 8'h01);
        check("a_sticky_int_hold", {7'b0, bus_a.interrupt}, 8'h01);
        tick();
        check("a_int_cleared", {7'b0, bus_a.interrupt}, 8'h00);
        check("a_rd_data_hold", bus_a.rd_data, 8'h01);
        bus_a.rd_req = 1'b1;
        tick();
        bus_a.rd_req = 1'b0;
        check("a_second_rd", bus_a.rd_data, 8'h00);

        // Mixed sticky/transparent, unsynchronized
        bus_b.status_in = 8'hA5;
        tick();
        bus_b.rd_req = 1'b1;
        tick();
        bus_b.rd_req = 1'b0;
        check("b_rd_a5", bus_b.rd_data, 8'hA5);
        bus_b.status_in = 8'h00;
        tick();
        tick();
        bus_b.rd_req = 1'b1;
        tick();
        check("b_rd_sticky_05", bus_b.rd_data, 8'h05);
        tick();
        bus_b.rd_req = 1'b0;
        check("b_rd_cleared", bus_b.rd_data, 8'h00);

        // Rising edge on bit1 coinciding with a read; back-to-back reads
        bus_b.status_in = 8'h02;
        bus_b.rd_req = 1'b1;
        tick();
        check("b_edge_same_cycle", bus_b.rd_data, 8'h00);
        tick();
        check("b_edge_next_rd", bus_b.rd_data, 8'h02);
        check("b_edge_rd_valid", {7'b0, bus_b.rd_valid}, 8'h01);
        tick();
        bus_b.rd_req = 1'b0;
        check("b_edge_no_retrigger", bus_b.rd_data, 8'h00);

        // Narrow transparent configuration, table-driven
        for (int i = 0; i < 7; i++) begin
            bus_c.status_in = vecs[i].stat;
            bus_c.mask_wr = 1'b1;
            bus_c.mask_data = vecs[i].mask;
            tick();
            bus_c.mask_wr = 1'b0;
            tick();
            bus_c.rd_req = 1'b1;
            tick();
            bus_c.rd_req = 1'b0;
            check($sformatf("c_vec%0d_rd", i), bus_c.rd_data, vecs[i].exp_rd);
            check($sformatf("c_vec%0d_valid", i), {7'b0, bus_c.rd_valid}, 8'h01);
            check($sformatf("c_vec%0d_int", i), {7'b0, bus_c.interrupt}, {7'b0, vecs[i].exp_int});
        end

        // Asynchronous reset between edges with captured state and interrupt high
        bus_b.status_in = 8'h3C;
        bus_b.mask_wr = 1'b1;
        bus_b.mask_data = 8'hFF;
        tick();
        bus_b.mask_wr = 1'b0;
        bus_b.rd_req = 1'b1;
        tick();
        bus_b.rd_req = 1'b0;
        check("b_pre_rst_rd", bus_b.rd_data, 8'h3C);
        check("b_pre_rst_int", {7'b0, bus_b.interrupt}, 8'h01);
        check("b_pre_rst_valid", {7'b0, bus_b.rd_valid}, 8'h01);
        #2;
        rst_b = 1'b1;
        #1;
        check("b_rst_rd_data", bus_b.rd_data, 8'h00);
        check("b_rst_int", {7'b0, bus_b.interrupt}, 8'h00);
        check("b_rst_valid", {7'b0, bus_b.rd_valid}, 8'h00);
        check("b_rst_st", dut_b.r_st, 8'h00);
        tick();
        rst_b = 1'b0;
        tick();
        check("b_post_rst_valid", {7'b0, bus_b.rd_valid}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
